// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner with a per-key debounce. Rows are driven one at a time, and a row's columns are sampled after SCAN_DIV-1 settle cycles.
// Latency: a key flips one cycle after its DEBOUNCE_SCANS-th agreeing sample. There is no backpressure. Optional macro KEYPAD_REMAP_EN selects the COSMAC hex layout.
module keypad_scan #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [3:0]  o_row_n,
    input  logic [3:0]  i_col_n,
    output logic [15:0] o_keypad_matrix,
    output logic        o_any_key,
    output logic        o_frame_tick
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DW-1:0] r_div_cnt;
    logic [1:0]    r_row;
    logic [3:0]    r_row_n;
    logic [3:0]    r_col_s1;
    logic [3:0]    r_col_s2;
    logic [15:0]   r_state;
    logic [7:0]    r_cnt [16];
    logic          r_any;
    logic          r_frame_tick;

    logic          w_sample;
    logic [3:0]    w_raw;
    logic [3:0]    w_key [4];

    // Physical position {row, col} to the key number that is stored in the debounce state.
    function automatic logic [3:0] f_key(input logic [3:0] pos);
`ifdef KEYPAD_REMAP_EN
        case (pos)
            4'd0:    return 4'h1;
            4'd1:    return 4'h2;
            4'd2:    return 4'h3;
            4'd3:    return 4'hC;
            4'd4:    return 4'h4;
            4'd5:    return 4'h5;
            4'd6:    return 4'h6;
            4'd7:    return 4'hD;
            4'd8:    return 4'h7;
            4'd9:    return 4'h8;
            4'd10:   return 4'h9;
            4'd11:   return 4'hE;
            4'd12:   return 4'hA;
            4'd13:   return 4'h0;
            4'd14:   return 4'hB;
            default: return 4'hF;
        endcase
`else
        return pos;
`endif
    endfunction

    assign w_sample = (r_div_cnt == DW'(SCAN_DIV - 1));
    assign w_raw    = ~r_col_s2;

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            w_key[c] = f_key({r_row, 2'(c)});
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt    <= '0;
            r_row        <= 2'd0;
            r_row_n      <= 4'b1110;
            r_col_s1     <= 4'b1111;
            r_col_s2     <= 4'b1111;
            r_frame_tick <= 1'b0;
        end else begin
            r_col_s1     <= i_col_n;
            r_col_s2     <= r_col_s1;
            r_frame_tick <= w_sample && (r_row == 2'd3);
            if (w_sample) begin
                r_div_cnt <= '0;
                r_row     <= r_row + 2'd1;
                r_row_n   <= {r_row_n[2:0], r_row_n[3]};
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Only the four keys of the row being sampled are touched on a sample cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= '0;
            r_any   <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                r_cnt[k] <= 8'd0;
            end
        end else begin
            r_any <= |r_state;
            if (w_sample) begin
                for (int c = 0; c < 4; c++) begin
                    if (w_raw[c] == r_state[w_key[c]]) begin
                        r_cnt[w_key[c]] <= 8'd0;
                    end else if (r_cnt[w_key[c]] == 8'(DEBOUNCE_SCANS - 1)) begin
                        r_state[w_key[c]] <= w_raw[c];
                        r_cnt[w_key[c]]   <= 8'd0;
                    end else begin
                        r_cnt[w_key[c]] <= r_cnt[w_key[c]] + 8'd1;
                    end
                end
            end
        end
    end

    assign o_row_n         = r_row_n;
    assign o_keypad_matrix = r_state;
    assign o_any_key       = r_any;
    assign o_frame_tick    = r_frame_tick;
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan. It emulates the key matrix, and a frame-level model predicts every output on every cycle.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keypad_matrix;
    logic        any_key;
    logic        frame_tick;

    logic [15:0] pressed = 16'h0;
    int          n_tests = 0;
    int          n_fail = 0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .i_clk(clk), .i_reset(reset), .o_row_n(row_n), .i_col_n(col_n),
        .o_keypad_matrix(keypad_matrix), .o_any_key(any_key), .o_frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Passive matrix: a column reads low when a held key sits on the row that is driven low.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            col_n[c] = 1'b1;
            for (int r = 0; r < 4; r++) begin
                if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
            end
        end
    end

`ifdef KEYPAD_REMAP_EN
    localparam logic [3:0] MAP [16] = '{4'h1, 4'h2, 4'h3, 4'hC, 4'h4, 4'h5, 4'h6, 4'hD,
                                        4'h7, 4'h8, 4'h9, 4'hE, 4'hA, 4'h0, 4'hB, 4'hF};
`else
    localparam logic [3:0] MAP [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                                        4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
`endif

    // The model tracks time since reset release. Row r of every 4*SD-cycle frame is sampled at cycle r*SD+SD-1.
    int          t;
    logic [15:0] m_state;
    int          m_cnt [16];
    logic [3:0]  m_row_n;
    logic        m_any;
    logic        m_ft;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t       <= 0;
            m_state <= '0;
            m_row_n <= 4'b1110;
            m_any   <= 1'b0;
            m_ft    <= 1'b0;
            for (int k = 0; k < 16; k++) m_cnt[k] <= 0;
        end else begin
            m_any   <= |m_state;
            m_ft    <= (t % (4*SD)) == (4*SD - 1);
            m_row_n <= ~(4'b0001 << (((t + 1) / SD) % 4));
            t       <= t + 1;
            if ((t % SD) == SD - 1) begin
                for (int c = 0; c < 4; c++) begin
                    int p;
                    int k;
                    p = ((t / SD) % 4) * 4 + c;
                    k = MAP[p];
                    if (pressed[p] == m_state[k]) m_cnt[k] <= 0;
                    else if (m_cnt[k] == DB - 1) begin
                        m_state[k] <= pressed[p];
                        m_cnt[k]   <= 0;
                    end else m_cnt[k] <= m_cnt[k] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("row_n", {28'd0, row_n}, {28'd0, m_row_n});
            check("keypad_matrix", {16'd0, keypad_matrix}, {16'd0, m_state});
            check("any_key", {31'd0, any_key}, {31'd0, m_any});
            check("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
        end
    end

    task automatic run_frame(input logic [15:0] p);
        pressed = p;
        repeat (4*SD) @(negedge clk);
    endtask

    task automatic check_reset_state();
        check("rst_row_n", {28'd0, row_n}, 32'h0000_000E);
        check("rst_matrix", {16'd0, keypad_matrix}, 32'h0);
        check("rst_any", {31'd0, any_key}, 32'h0);
        check("rst_tick", {31'd0, frame_tick}, 32'h0);
    endtask

    logic [15:0] k00;
    logic [15:0] k31;
    logic [15:0] rp;

    initial begin
`ifdef KEYPAD_REMAP_EN
        k00 = 16'h0002;
        k31 = 16'h0001;
`else
        k00 = 16'h0001;
        k31 = 16'h2000;
`endif
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state();
        reset = 1'b0;

        // Row walk and frame tick over the first idle frame.
        pressed = 16'h0;
        check("walk_r0", {28'd0, row_n}, 32'hE);
        repeat (SD) @(negedge clk);
        check("walk_r1", {28'd0, row_n}, 32'hD);
        repeat (SD) @(negedge clk);
        check("walk_r2", {28'd0, row_n}, 32'hB);
        repeat (SD) @(negedge clk);
        check("walk_r3", {28'd0, row_n}, 32'h7);
        repeat (SD - 1) @(negedge clk);
        check("tick_low", {31'd0, frame_tick}, 32'h0);
        @(negedge clk);
        check("walk_wrap", {28'd0, row_n}, 32'hE);
        check("tick_high", {31'd0, frame_tick}, 32'h1);

        // Clean press of r0,c0.
        run_frame(16'h0001);
        run_frame(16'h0001);
        check("press_early", {16'd0, keypad_matrix}, 32'h0);
        run_frame(16'h0001);
        check("press_set", {16'd0, keypad_matrix}, {16'd0, k00});
        check("press_any", {31'd0, any_key}, 32'h1);

        // Release with a one-frame re-press glitch.
        run_frame(16'h0000);
        run_frame(16'h0000);
        run_frame(16'h0001);
        run_frame(16'h0000);
        run_frame(16'h0000);
        check("release_hold", {16'd0, keypad_matrix}, {16'd0, k00});
        run_frame(16'h0000);
        check("release_clr", {16'd0, keypad_matrix}, 32'h0);

        // Bounce: held, open, held, held, held.
        run_frame(16'h0001);
        run_frame(16'h0000);
        run_frame(16'h0001);
        run_frame(16'h0001);
        check("bounce_wait", {16'd0, keypad_matrix}, 32'h0);
        run_frame(16'h0001);
        check("bounce_set", {16'd0, keypad_matrix}, {16'd0, k00});
        repeat (3) run_frame(16'h0000);
        check("bounce_clr", {16'd0, keypad_matrix}, 32'h0);

        // Two keys together: r1,c2 and r3,c3.
        repeat (3) run_frame(16'h8040);
        check("multi", {16'd0, keypad_matrix}, 32'h8040);
        repeat (3) run_frame(16'h0000);

        // r3,c1.
        repeat (3) run_frame(16'h2000);
        check("r3c1", {16'd0, keypad_matrix}, {16'd0, k31});

        // Reset mid-frame while a key is held.
        repeat (7) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_reset_state();
        @(negedge clk);
        pressed = 16'h0;
        reset = 1'b0;
        run_frame(16'h0000);

        // Randomised frames: sticky patterns with occasional changes.
        rp = 16'h0;
        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 3) == 0) rp = 16'($urandom) & 16'($urandom);
            else if ($urandom_range(0, 2) == 0) rp = rp ^ (16'h1 << $urandom_range(0, 15));
            run_frame(rp);
        end
        repeat (4) run_frame(16'h0000);
        check("final_clr", {16'd0, keypad_matrix}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
